dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8; word-index width, giving 2^ADDR_W 64-bit words.
REQ-002 SHALL have parameter LATENCY, default 2; cycles from request accept to resp_valid, legal range 1..15.
REQ-003 SHALL have parameter BASE, default 64'h0000000080000000; byte address of word 0.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports declared first:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
REQ-005 SHALL have these remaining ports:
- req_valid  in  1  request present
- req_ready  out  1  responder can accept
- req_wen  in  1  1=write, 0=read
- req_addr  in  64  byte address
- req_wdata  in  64  write data, LSB-aligned
- req_wmask  in  8  byte mask, LSB-aligned (sd=FF, sw=0F, sh=03, sb=01)
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_rdata  out  64  read data, LSB-aligned
- resp_err  out  1  access error

Function
REQ-006 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; req_ready=1 only in IDLE.
REQ-007 SHALL accept a request on a rising edge with req_valid&&req_ready; inputs are ignored in all other cycles.
REQ-008 SHALL compute off=req_addr[2:0] and idx=(req_addr-BASE)[ADDR_W+2:3].
REQ-009 SHALL, on an accepted write, write byte k of word idx from (req_wdata<<8*off) wherever (req_wmask<<off)[k]=1, on the accept edge.
REQ-010 SHALL, on an accepted read, register (mem[idx]>>8*off) on the accept edge, with upper bytes zero-filled.
REQ-011 SHALL set resp_rdata to 0 for writes.
REQ-012 SHALL, on accept, go to RESP if LATENCY=1; otherwise go to WAIT with a counter loaded to LATENCY-2.
REQ-013 SHALL, in WAIT, decrement the counter each cycle and go to RESP when the counter is 0.
REQ-014 SHALL assert resp_valid in RESP only, with resp_valid rising exactly LATENCY cycles after the accept edge.
REQ-015 SHALL hold resp_valid, resp_rdata and resp_err stable until resp_ready=1, then go to IDLE on that edge.
REQ-016 SHALL keep a response stalled indefinitely while resp_ready=0, with no data loss.
REQ-017 SHALL make a read accepted after a write response return the written data (read-after-write is coherent).
REQ-018 SHALL ignore resp_ready outside RESP.

Reset
REQ-019 SHALL, while rst_n=0 and independent of clk, force: state IDLE, counter 0, req_ready 0, resp_valid 0, resp_rdata 0, resp_err 0.
REQ-020 SHALL assert req_ready in the first cycle after rst_n deasserts.
REQ-021 SHALL not reset memory contents.
REQ-022 SHALL, on reset mid-transaction, discard any pending response; a write already committed on its accept edge stays committed.

Configuration
REQ-023 SHALL, when DMEM_RESP_ERR_EN is defined, flag resp_err=1 in the response for:
- req_addr<BASE;
- req_addr>=BASE+8*2^ADDR_W;
- a write whose (req_wmask<<off) has any bit set above bit 7.
REQ-024 SHALL, when DMEM_RESP_ERR_EN is defined and resp_err=1, leave memory unmodified and return resp_rdata=0, with timing unchanged.
REQ-025 SHALL, when DMEM_RESP_ERR_EN is undefined, tie resp_err to 0, wrap idx modulo 2^ADDR_W, and silently drop shifted mask bits above bit 7.

Verification
REQ-026 Bench SHALL cover: write 0x1122334455667788 mask FF at 0x80000000, then read at 0x80000000 -> resp_rdata=0x1122334455667788, resp_err=0.
REQ-027 Bench SHALL cover: write 0xAB mask 01 at 0x80000003, then read at 0x80000000 -> byte 3 =0xAB, other bytes unchanged; read at 0x80000003 -> resp_rdata[7:0]=0xAB.
REQ-028 Bench SHALL cover: LATENCY=3 with a read accepted at edge N -> resp_valid=1 from edge N+3; resp_ready held 0 for 5 cycles -> resp_valid and data stable and req_ready=0 throughout.
REQ-029 Bench SHALL cover: with DMEM_RESP_ERR_EN defined, read at 0x7FFFFFF8 -> resp_err=1, resp_rdata=0; write mask 0F at 0x80000006 -> resp_err=1 and the word is unchanged.
REQ-030 Bench SHALL cover: rst_n pulled low in WAIT -> resp_valid=0 immediately; after release req_ready=1 and no stale response appears.
REQ-031 Bench SHALL cover: LATENCY=1 with back-to-back requests and resp_ready tied 1 -> one transaction every 2 cycles, responses in order.

Source files
------------

// File: rtl/dmem_responder.sv
// Single-port 64-bit data-memory responder: one request in flight, fixed response latency.
// Optional macro DMEM_RESP_ERR_EN enables range and mask-overflow error responses.
module dmem_responder #(
    parameter int          ADDR_W  = 8,
    parameter int          LATENCY = 2,
    parameter logic [63:0] BASE    = 64'h0000000080000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state, state_nxt;
    logic [3:0]         cnt, cnt_nxt;
    logic [63:0]        mem [2**ADDR_W];
    logic [63:0]        rdata_q;
    logic               err_q;

    logic               accept;
    logic [2:0]         off;
    logic [ADDR_W-1:0]  idx;
    logic [63:0]        wdata_sh;
    logic               err;

    assign off      = req_addr[2:0];
    assign idx      = ADDR_W'((req_addr - BASE) >> 3);
    assign wdata_sh = req_wdata << {off, 3'b000};

`ifdef DMEM_RESP_ERR_EN
    localparam logic [63:0] LIMIT = BASE + (64'd8 << ADDR_W);
    logic [14:0] mask_sh;
    assign mask_sh = {7'b0, req_wmask} << off;
    assign err     = (req_addr < BASE) || (req_addr >= LIMIT) || (req_wen && (|mask_sh[14:8]));
`else
    // Bits shifted past byte 7 fall off here; idx wraps through truncation.
    logic [7:0] mask_sh;
    assign mask_sh = req_wmask << off;
    assign err     = 1'b0;
`endif

    // Gating with rst_n keeps req_ready low while reset is held.
    assign req_ready  = rst_n && (state == IDLE);
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = 4'(LATENCY - 2);
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_nxt = RESP;
                else             cnt_nxt   = cnt - 4'd1;
            end
            RESP: begin
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Response data is captured at accept, so a stalled response never changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
        end else if (accept) begin
            err_q   <= err;
            rdata_q <= (req_wen || err) ? 64'd0 : (mem[idx] >> {off, 3'b000});
        end
    end

    // Memory has no reset; a write commits on its accept edge.
    always_ff @(posedge clk) begin
        if (accept && req_wen && !err) begin
            for (int k = 0; k < 8; k++) begin
                if (mask_sh[k]) mem[idx][8*k +: 8] <= wdata_sh[8*k +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at LATENCY=3, one at LATENCY=1.
module tb_dmem_responder;

    localparam int LAT_A = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          n_vec = 0;
    int          n_bad = 0;

    logic        a_req_valid = 1'b0, a_req_ready, a_req_wen = 1'b0;
    logic [63:0] a_req_addr = '0, a_req_wdata = '0;
    logic [7:0]  a_req_wmask = '0;
    logic        a_resp_valid, a_resp_ready = 1'b0, a_resp_err;
    logic [63:0] a_resp_rdata;

    logic        b_req_valid = 1'b0, b_req_ready, b_req_wen = 1'b0;
    logic [63:0] b_req_addr = '0, b_req_wdata = '0;
    logic [7:0]  b_req_wmask = '0;
    logic        b_resp_valid, b_resp_ready = 1'b1, b_resp_err;
    logic [63:0] b_resp_rdata;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(8), .LATENCY(LAT_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_wen(a_req_wen),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_wmask(a_req_wmask),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
    );

    dmem_responder #(.ADDR_W(8), .LATENCY(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wen(b_req_wen),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wmask(b_req_wmask),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transaction on instance A; response is held unconsumed for 'hold' cycles.
    task automatic a_txn(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [7:0] wmask, input int hold,
                         output logic [63:0] rdata, output logic err);
        int n;
        int lat;
        @(negedge clk);
        a_req_valid = 1'b1; a_req_wen = wen; a_req_addr = addr;
        a_req_wdata = wdata; a_req_wmask = wmask; a_resp_ready = 1'b0;
        n = 0;
        while (!a_req_ready && n < 50) begin @(negedge clk); n++; end
        chk("a_ready_before_accept", a_req_ready, 1);
        @(posedge clk); #1;
        a_req_valid = 1'b0; a_req_addr = 64'hDEAD_BEEF_0000_0000; a_req_wdata = '1; a_req_wmask = 8'hFF;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!a_resp_valid && lat < 40);
        chk("a_latency", lat, LAT_A);
        rdata = a_resp_rdata;
        err   = a_resp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("stall_valid", a_resp_valid, 1);
            chk("stall_rdata", a_resp_rdata, rdata);
            chk("stall_err", a_resp_err, err);
            chk("stall_req_ready", a_req_ready, 0);
        end
        a_resp_ready = 1'b1;
        @(posedge clk); #1;
        a_resp_ready = 1'b0;
        @(negedge clk);
        chk("a_idle_after_resp", a_req_ready, 1);
        chk("a_valid_dropped", a_resp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rd;
        logic        er;
        logic        stale;
        logic        b_wen  [4];
        logic [63:0] b_addr [4];
        logic [63:0] b_data [4];
        logic [63:0] b_exp  [4];
        int          b_acc  [4];
        int          bi, br, cyc;

        #1;
        chk("rst_req_ready", a_req_ready, 0);
        chk("rst_resp_valid", a_resp_valid, 0);
        chk("rst_resp_rdata", a_resp_rdata, 0);
        chk("rst_resp_err", a_resp_err, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", a_req_ready, 1);

        // Full-word write and read-back
        a_txn(1, 64'h8000_0000, 64'h1122334455667788, 8'hFF, 0, rd, er);
        chk("wr_rdata_zero", rd, 0);
        chk("wr_err", er, 0);
        a_txn(0, 64'h8000_0000, 0, 0, 0, rd, er);
        chk("rd_word0", rd, 64'h1122334455667788);
        chk("rd_word0_err", er, 0);

        // Byte write at offset 3
        a_txn(1, 64'h8000_0003, 64'h00000000000000AB, 8'h01, 0, rd, er);
        a_txn(0, 64'h8000_0000, 0, 0, 0, rd, er);
        chk("rd_after_sb", rd, 64'h11223344AB667788);
        a_txn(0, 64'h8000_0003, 0, 0, 0, rd, er);
        chk("rd_off3", rd, 64'h00000011223344AB);
        chk("rd_off3_byte", rd[7:0], 8'hAB);

        // Halfword write at offset 6, then a second word and an offset-7 read
        a_txn(1, 64'h8000_0006, 64'h000000000000BEEF, 8'h03, 0, rd, er);
        chk("sh_err", er, 0);
        a_txn(1, 64'h8000_0008, 64'h0123456789ABCDEF, 8'hFF, 0, rd, er);
        a_txn(0, 64'h8000_000F, 0, 0, 0, rd, er);
        chk("rd_word1_off7", rd, 64'h0000000000000001);

        // Stalled response held for 5 cycles
        a_txn(0, 64'h8000_0000, 0, 0, 5, rd, er);
        chk("stall_data", rd, 64'hBEEF3344AB667788);

`ifdef DMEM_RESP_ERR_EN
        a_txn(0, 64'h7FFF_FFF8, 0, 0, 0, rd, er);
        chk("err_below_base", er, 1);
        chk("err_below_rdata", rd, 0);
        a_txn(0, 64'h8000_0800, 0, 0, 0, rd, er);
        chk("err_above_top", er, 1);
        a_txn(1, 64'h8000_0006, 64'h00000000FFFFFFFF, 8'h0F, 0, rd, er);
        chk("err_mask_ovf", er, 1);
        a_txn(0, 64'h8000_0000, 0, 0, 0, rd, er);
        chk("err_word_unchanged", rd, 64'hBEEF3344AB667788);
        chk("err_clear_on_good", er, 0);
`else
        a_txn(1, 64'h8000_0800, 64'h0000000000005555, 8'h03, 0, rd, er);
        chk("wrap_err", er, 0);
        a_txn(1, 64'h8000_0006, 64'h00000000FFFFFFFF, 8'h0F, 0, rd, er);
        chk("ovf_err", er, 0);
        a_txn(0, 64'h8000_0000, 0, 0, 0, rd, er);
        chk("wrap_and_drop", rd, 64'hFFFF3344AB665555);
`endif

        // Reset while the read sits in WAIT
        @(negedge clk);
        a_req_valid = 1'b1; a_req_wen = 1'b0; a_req_addr = 64'h8000_0000; a_resp_ready = 1'b0;
        chk("pre_rst_ready", a_req_ready, 1);
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", a_resp_valid, 0);
        chk("midrst_ready", a_req_ready, 0);
        chk("midrst_rdata", a_resp_rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("postrst_ready", a_req_ready, 1);
        stale = 1'b0;
        a_resp_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (a_resp_valid) stale = 1'b1;
        end
        a_resp_ready = 1'b0;
        chk("no_stale_resp", stale, 0);
        a_txn(0, 64'h8000_0008, 0, 0, 0, rd, er);
        chk("mem_kept_over_reset", rd, 64'h0123456789ABCDEF);

        // LATENCY=1 back-to-back with resp_ready tied high
        b_wen[0] = 1; b_addr[0] = 64'h8000_0000; b_data[0] = 64'hA0A1A2A3A4A5A6A7; b_exp[0] = 0;
        b_wen[1] = 1; b_addr[1] = 64'h8000_0008; b_data[1] = 64'hB0B1B2B3B4B5B6B7; b_exp[1] = 0;
        b_wen[2] = 0; b_addr[2] = 64'h8000_0000; b_data[2] = 0; b_exp[2] = 64'hA0A1A2A3A4A5A6A7;
        b_wen[3] = 0; b_addr[3] = 64'h8000_0008; b_data[3] = 0; b_exp[3] = 64'hB0B1B2B3B4B5B6B7;
        bi = 0; br = 0;
        for (cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (b_resp_valid) begin
                if (br < 4) begin
                    chk("b_rdata", b_resp_rdata, b_exp[br]);
                    chk("b_err", b_resp_err, 0);
                end
                br++;
            end
            if (bi < 4 && b_req_ready) begin
                b_req_valid = 1'b1; b_req_wen = b_wen[bi]; b_req_addr = b_addr[bi];
                b_req_wdata = b_data[bi]; b_req_wmask = 8'hFF;
                b_acc[bi] = cyc;
                bi++;
            end else if (bi >= 4) begin
                b_req_valid = 1'b0;
            end
        end
        chk("b_accepted", bi, 4);
        chk("b_responses", br, 4);
        if (bi == 4) begin
            for (int i = 1; i < 4; i++) chk("b_interval", b_acc[i] - b_acc[i-1], 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
